// File: rtl/legv8_pkg.sv
// LEGv8 instruction-format enum, field geometry, opcode table and immediate range helpers.
// Also provides the default address width macro WORD when the build does not set one.
`ifndef WORD
`define WORD 32
`endif

package legv8_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_B  = 3'd3,
        FMT_CB = 3'd4,
        FMT_IW = 3'd5
    } fmt_e;

    localparam int OP_W     = 11;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 6;
    localparam int IMM_W    = 32;
    localparam int INSTR_W  = 32;

    localparam int I_IMM_W  = 12;
    localparam int D_IMM_W  = 9;
    localparam int B_IMM_W  = 26;
    localparam int CB_IMM_W = 19;
    localparam int IW_IMM_W = 16;

    localparam int RM_LSB     = 16;
    localparam int SHAMT_LSB  = 10;
    localparam int RN_LSB     = 5;
    localparam int I_IMM_LSB  = 10;
    localparam int D_IMM_LSB  = 12;
    localparam int CB_IMM_LSB = 5;
    localparam int IW_IMM_LSB = 5;

    localparam logic [OP_W-1:0] OP_LDUR = 11'h7C2;
    localparam logic [OP_W-1:0] OP_STUR = 11'h7C0;
    localparam logic [OP_W-1:0] OP_ADD  = 11'h458;
    localparam logic [OP_W-1:0] OP_SUB  = 11'h658;
    localparam logic [OP_W-1:0] OP_AND  = 11'h450;
    localparam logic [OP_W-1:0] OP_ORR  = 11'h550;
    localparam logic [OP_W-1:0] OP_B    = 11'h0A0;
    localparam logic [OP_W-1:0] OP_CBZ  = 11'h5A0;

    // True when v, read as two's complement, fits a w-bit signed field.
    function automatic logic fits_signed(input logic [IMM_W-1:0] v, input int w);
        logic signed [IMM_W-1:0] t;
        t = $signed(v) >>> (w - 1);
        return (t == '0) || (t == '1);
    endfunction

    function automatic logic fits_unsigned(input logic [IMM_W-1:0] v, input int w);
        return (v >> w) == '0;
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational LEGv8 field packer: format + fields -> 32-bit word and range error.
// Range checking exists only when INSTR_ENC_CHECK_EN is defined; otherwise fields truncate.
module instr_field_pack
    import legv8_pkg::*;
(
    input  logic [2:0]         fmt_i,
    input  logic [OP_W-1:0]    opcode_i,
    input  logic [REG_W-1:0]   rd_i,
    input  logic [REG_W-1:0]   rn_i,
    input  logic [REG_W-1:0]   rm_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [IMM_W-1:0]   imm_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               range_err_o
);

    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_i[IMM_W-1:B_IMM_W];

    always_comb begin
        word_o = '0;
        case (fmt_i)
            FMT_I:   word_o = {opcode_i[10:1], imm_i[I_IMM_W-1:0], rn_i, rd_i};
            FMT_D:   word_o = {opcode_i, imm_i[D_IMM_W-1:0], 2'b00, rn_i, rd_i};
            FMT_B:   word_o = {opcode_i[10:5], imm_i[B_IMM_W-1:0]};
            FMT_CB:  word_o = {opcode_i[10:3], imm_i[CB_IMM_W-1:0], rd_i};
            FMT_IW:  word_o = {opcode_i, imm_i[IW_IMM_W-1:0], rd_i};
            // R, and the illegal codes when unchecked
            default: word_o = {opcode_i, rm_i, shamt_i, rn_i, rd_i};
        endcase
    end

`ifdef INSTR_ENC_CHECK_EN
    always_comb begin
        range_err_o = 1'b0;
        case (fmt_i)
            FMT_R:   range_err_o = 1'b0;
            FMT_I:   range_err_o = !fits_unsigned(imm_i, I_IMM_W);
            FMT_D:   range_err_o = !fits_signed(imm_i, D_IMM_W);
            FMT_B:   range_err_o = !fits_signed(imm_i, B_IMM_W);
            FMT_CB:  range_err_o = !fits_signed(imm_i, CB_IMM_W);
            FMT_IW:  range_err_o = !fits_unsigned(imm_i, IW_IMM_W);
            default: range_err_o = 1'b1;
        endcase
    end
`else
    assign range_err_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// LEGv8 encoder: two-stage valid/ready pipeline, 2-cycle latency, 1 word/cycle; stalls hold out_*.
// INSTR_ENC_CHECK_EN enables range rejection with err pulse and err_count.
module instr_encoder
    import legv8_pkg::*;
#(
    parameter logic [`WORD-1:0] BASE_ADDR = '0,
    parameter int               CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [OP_W-1:0]    in_opcode,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_rn,
    input  logic [REG_W-1:0]   in_rm,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [IMM_W-1:0]   in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [`WORD-1:0]   out_addr,
    output logic [CNT_W-1:0]   out_count,
    output logic               err,
    output logic [7:0]         err_count
);

    logic [INSTR_W-1:0] enc_word;
    logic               enc_err;

    instr_field_pack u_pack (
        .fmt_i       (in_fmt),
        .opcode_i    (in_opcode),
        .rd_i        (in_rd),
        .rn_i        (in_rn),
        .rm_i        (in_rm),
        .shamt_i     (in_shamt),
        .imm_i       (in_imm),
        .word_o      (enc_word),
        .range_err_o (enc_err)
    );

    logic               s1_valid_q, s1_valid_d;
    logic [INSTR_W-1:0] s1_instr_q, s1_instr_d;
    logic               s2_valid_q, s2_valid_d;
    logic [INSTR_W-1:0] s2_instr_q, s2_instr_d;
    logic [`WORD-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic out_fire, s1_adv, in_fire;

    assign out_fire = s2_valid_q & out_ready;
    assign s1_adv   = !s2_valid_q | out_fire;
    assign in_ready = !s1_valid_q | s1_adv;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_instr_d = s1_instr_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        addr_d     = addr_q;
        count_d    = count_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) s2_instr_d = s1_instr_q;
            s1_valid_d = 1'b0;
        end

        // Rejected words never enter stage 1, so they consume no address.
        if (in_fire) begin
            if (enc_err) begin
                err_d = 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                s1_valid_d = 1'b1;
                s1_instr_d = enc_word;
            end
        end

        if (out_fire) begin
            addr_d = addr_q + `WORD'(4);
            if (count_q != '1) count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_instr_q <= s1_instr_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_addr  = addr_q;
    assign out_count = count_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded LEGv8 words, addresses, stalls, reject and reset.
module tb_instr_encoder;
    import legv8_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_fmt = '0;
    logic [10:0]       in_opcode = '0;
    logic [4:0]        in_rd = '0, in_rn = '0, in_rm = '0;
    logic [5:0]        in_shamt = '0;
    logic [31:0]       in_imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [`WORD-1:0]  out_addr;
    logic [15:0]       out_count;
    logic              err;
    logic [7:0]        err_count;

    instr_encoder #(.BASE_ADDR('0), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rn     (in_rn),
        .in_rm     (in_rm),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_count (out_count),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transfers happen at the next posedge; inputs only change at posedge+1.
    logic [31:0]      got_w[$];
    logic [`WORD-1:0] got_a[$];
    int               acc_cnt = 0;
    int               err_pulses = 0;
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got_w.push_back(out_instr);
            got_a.push_back(out_addr);
        end
        if (!reset && in_valid && in_ready) acc_cnt++;
        if (!reset && err) err_pulses++;
    end

    task automatic send(input logic [2:0] f, input logic [10:0] op, input logic [4:0] rd,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [5:0] sh,
                        input logic [31:0] imm);
        bit acc;
        in_fmt = f; in_opcode = op; in_rd = rd; in_rn = rn; in_rm = rm;
        in_shamt = sh; in_imm = imm; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", acc, 1);
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 60; i++) begin
            if (got_w.size() >= n) break;
            @(posedge clk);
            #1;
        end
        chk("word_count", got_w.size(), n);
    endtask

    int  a0;
    int  nb;
    bit  bp_done = 1'b0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr",  out_addr, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_err",       err, 0);
        chk("rst_err_count", err_count, 0);

        // LDUR X9, [X22, #64] and its two-edge latency
        out_ready = 1'b1;
        send(FMT_D, OP_LDUR, 5'd9, 5'd22, 5'd0, 6'd0, 32'd64);
        chk("lat_after_accept", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_next_edge", out_valid, 1);
        chk("ldur_instr", out_instr, 32'hF84402C9);
        chk("ldur_addr",  out_addr, 0);
        wait_words(1);
        chk("ldur_q_w", got_w[0], 32'hF84402C9);
        chk("ldur_q_a", got_a[0], 0);

        // Back-to-back ADD, CBZ, B
        send(FMT_R,  OP_ADD, 5'd10, 5'd19, 5'd9, 6'd0, 32'd0);
        send(FMT_CB, OP_CBZ, 5'd11, 5'd0,  5'd0, 6'd0, -32'sd5);
        send(FMT_B,  OP_B,   5'd0,  5'd0,  5'd0, 6'd0, -32'sd55);
        wait_words(4);
        chk("add_w", got_w[1], 32'h8B09026A);  chk("add_a", got_a[1], 4);
        chk("cbz_w", got_w[2], 32'hB4FFFF6B);  chk("cbz_a", got_a[2], 8);
        chk("b_w",   got_w[3], 32'h17FFFFC9);  chk("b_a",   got_a[3], 12);
        @(posedge clk); #1;
        chk("count_4", out_count, 4);

        // Backpressure: 3 offered, 5 stalled cycles
        out_ready = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                send(FMT_R, OP_AND, 5'd1, 5'd2, 5'd3, 6'd0, 32'd0);
                send(FMT_R, OP_ORR, 5'd4, 5'd5, 5'd6, 6'd0, 32'd0);
                send(FMT_R, OP_SUB, 5'd7, 5'd8, 5'd9, 6'd2, 32'd0);
                bp_done = 1'b1;
            end
        join_none
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 2 || c == 4) chk("bp_instr_hold", out_instr, 32'h8A030041);
        end
        chk("bp_accepts", acc_cnt - a0, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_no_leak", got_w.size(), 4);
        out_ready = 1'b1;
        for (int i = 0; i < 60 && !bp_done; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_sender_done", bp_done, 1);
        wait_words(7);
        chk("and_w", got_w[4], 32'h8A030041);  chk("and_a", got_a[4], 16);
        chk("orr_w", got_w[5], 32'hAA0600A4);  chk("orr_a", got_a[5], 20);
        chk("sub_w", got_w[6], 32'hCB090907);  chk("sub_a", got_a[6], 24);

        // I and IW formats: ADDI X2,X1,#5 and MOVZ X3,#0x1234
        send(FMT_I,  11'h488, 5'd2, 5'd1, 5'd0, 6'd0, 32'd5);
        send(FMT_IW, 11'h694, 5'd3, 5'd0, 5'd0, 6'd0, 32'h1234);
        wait_words(9);
        chk("addi_w", got_w[7], 32'h91001422); chk("addi_a", got_a[7], 28);
        chk("movz_w", got_w[8], 32'hD2824683); chk("movz_a", got_a[8], 32);

`ifdef INSTR_ENC_CHECK_EN
        // Out-of-range D immediate is rejected and consumes no address
        send(FMT_D, OP_LDUR, 5'd9, 5'd22, 5'd0, 6'd0, 32'd256);
        repeat (3) begin @(posedge clk); #1; end
        chk("rej_err_pulses", err_pulses, 1);
        chk("rej_err_count", err_count, 1);
        chk("rej_no_output", got_w.size(), 9);
        send(FMT_I, 11'h488, 5'd2, 5'd1, 5'd0, 6'd0, 32'd5);
        wait_words(10);
        chk("after_rej_w", got_w[9], 32'h91001422);
        chk("after_rej_a", got_a[9], 36);
        nb = 10;
`else
        // Illegal format packs as R; oversize D immediate truncates to 9 bits
        send(3'd6,  OP_ADD,  5'd1, 5'd2,  5'd3, 6'd0, 32'd0);
        send(FMT_D, OP_LDUR, 5'd9, 5'd22, 5'd0, 6'd0, 32'd256);
        wait_words(11);
        chk("illegal_w", got_w[9],  32'h8B030041); chk("illegal_a", got_a[9], 36);
        chk("trunc_w",   got_w[10], 32'hF85002C9); chk("trunc_a",   got_a[10], 40);
        repeat (2) begin @(posedge clk); #1; end
        chk("err_tied", err_pulses, 0);
        chk("err_count_tied", err_count, 0);
        nb = 11;
`endif
        @(posedge clk); #1;
        chk("count_total", out_count, nb);

        // Reset with two words in flight
        out_ready = 1'b0;
        send(FMT_R, OP_AND, 5'd1, 5'd2, 5'd3, 6'd0, 32'd0);
        send(FMT_R, OP_ORR, 5'd4, 5'd5, 5'd6, 6'd0, 32'd0);
        chk("pre_rst_in_ready", in_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_addr", out_addr, 0);
        chk("mid_rst_count", out_count, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        send(FMT_D, OP_LDUR, 5'd9, 5'd22, 5'd0, 6'd0, 32'd64);
        wait_words(nb + 1);
        chk("post_rst_w", got_w[nb], 32'hF84402C9);
        chk("post_rst_a", got_a[nb], 0);
        @(posedge clk); #1;
        chk("post_rst_count", out_count, 1);
        chk("post_rst_idle", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
